// File: rtl/uart_stream_scheduler_if.sv
// Read side of the two camera FIFOs plus the byte handshake into uart_tx.
// master = scheduler, slave = FIFOs/transmitter environment.
interface uart_stream_scheduler_if;
   logic [1:0]  ch_empty;
   logic [1:0]  ch_almost_empty;
   logic [15:0] ch_data;
   logic [1:0]  ch_rinc;
   logic        tx_busy;
   logic        tx_valid;
   logic [7:0]  tx_data;

   modport master (
      input  ch_empty,
      input  ch_almost_empty,
      input  ch_data,
      input  tx_busy,
      output ch_rinc,
      output tx_valid,
      output tx_data
   );

   modport slave (
      output ch_empty,
      output ch_almost_empty,
      output ch_data,
      output tx_busy,
      input  ch_rinc,
      input  tx_valid,
      input  tx_data
   );
endinterface

// File: rtl/uart_stream_scheduler.sv
// Round-robin scheduler draining two camera FIFOs into one UART in framed bursts:
// SYNC0, SYNC1, {seq, ch}, up to BURST_LEN data bytes (legal 1..255), byte-count trailer.
module uart_stream_scheduler #(
   parameter int unsigned BURST_LEN = 64,
   parameter logic [7:0]  SYNC0     = 8'hA5,
   parameter logic [7:0]  SYNC1     = 8'h5A
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           enable_i,
   uart_stream_scheduler_if.master        bus,
   output logic [1:0]                     grant_o,
   output logic                           burst_active_o,
   output logic [15:0]                    bursts_sent_o
);

   localparam logic [7:0] BurstLenB = 8'(BURST_LEN);

   typedef enum logic [2:0] {
      StIdle,
      StHdr0,
      StHdr1,
      StHdr2,
      StRdReq,
      StRdWait,
      StDataTx,
      StTrailer
   } state_e;

   state_e          state_q, state_d;
   logic            last_grant_q;  // owning channel during a burst, previous owner when idle
   logic [7:0]      count_q;
   logic [1:0][3:0] seq_q;
   logic [15:0]     bursts_q;
   logic            tx_valid_q;

   logic [1:0] ready;
   logic       can_send;
   logic       start;
   logic       pick;
   logic       g;
   logic       rd_done;

   assign ready    = ~bus.ch_empty & ~bus.ch_almost_empty;
   assign can_send = ~bus.tx_busy & ~tx_valid_q;
   assign start    = enable_i & (|ready);
   assign pick     = ready[~last_grant_q] ? ~last_grant_q : last_grant_q;
   assign g        = last_grant_q;
   assign rd_done  = (count_q == BurstLenB) | ~ready[g];

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StHdr0;
         StHdr0:    if (can_send) state_d = StHdr1;
         StHdr1:    if (can_send) state_d = StHdr2;
         StHdr2:    if (can_send) state_d = StRdReq;
         StRdReq: begin
            if (rd_done) begin
               state_d = StTrailer;
            end else if (can_send) begin
               state_d = StRdWait;
            end
         end
         StRdWait:  state_d = StDataTx;
         StDataTx:  state_d = StRdReq;
         StTrailer: if (can_send) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.ch_rinc  = 2'b00;
      unique case (state_q)
         StHdr0: begin
            bus.tx_valid = can_send;
            bus.tx_data  = can_send ? SYNC0 : 8'h00;
         end
         StHdr1: begin
            bus.tx_valid = can_send;
            bus.tx_data  = can_send ? SYNC1 : 8'h00;
         end
         StHdr2: begin
            bus.tx_valid = can_send;
            bus.tx_data  = can_send ? {seq_q[g], 3'b000, g} : 8'h00;
         end
         StRdReq: begin
            if (!rd_done && can_send) begin
               bus.ch_rinc[g] = 1'b1;
            end
         end
         // Busy cannot rise without a strobe, so the check done in StRdReq still holds here
         StDataTx: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = g ? bus.ch_data[15:8] : bus.ch_data[7:0];
         end
         StTrailer: begin
            bus.tx_valid = can_send;
            bus.tx_data  = can_send ? count_q : 8'h00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_grant_q <= 1'b1;
         count_q      <= 8'h00;
         seq_q        <= '0;
         bursts_q     <= 16'h0000;
         tx_valid_q   <= 1'b0;
      end else begin
         tx_valid_q <= bus.tx_valid;
         if (state_q == StIdle && start) begin
            last_grant_q <= pick;
            count_q      <= 8'h00;
         end
         if (state_q == StDataTx) begin
            count_q <= count_q + 8'h01;
         end
         if (state_q == StTrailer && can_send) begin
            seq_q[g] <= seq_q[g] + 4'h1;
            bursts_q <= bursts_q + 16'h0001;
         end
      end
   end

   assign grant_o        = (state_q != StIdle) ? {g, ~g} : 2'b00;
   assign burst_active_o = (state_q != StIdle);
   assign bursts_sent_o  = bursts_q;

   a_no_back_to_back: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(bus.tx_valid && tx_valid_q));
   a_rinc_granted: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (bus.ch_rinc != 2'b00) |-> (bus.ch_rinc == grant_o));

endmodule
